apb_regfile_slave: RTL and testbench

APB completer (responder) holding a byte-wide register bank. It adds a programmable number of wait states and flags PSLVERR on unmapped addresses. It sits behind the APB master's PSELx/PENABLE/PWRITE/PADDR/PWDATA outputs and returns PREADY/PRDATA/PSLVERR. It is a drop-in slave for the two-slave APB subsystem and the counterpart to the master's transfer sequencing.

---
 rtl/apb_pkg.sv | 14 +
 rtl/apb_regfile_slave_if.sv | 27 ++
 rtl/apb_regfile_slave_regbank.sv | 31 +++
 rtl/apb_regfile_slave.sv | 162 ++++++++++++++++
 tb/tb_apb_regfile_slave.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB register-file slave.
// Holds the FSM state enum, the config address and the wait-config width.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    READY
  } apb_slv_state_t;

  localparam logic [7:0] CFG_ADDR = 8'hFF;
  localparam int         WAIT_W   = 3;

endpackage

// File: rtl/apb_regfile_slave_if.sv
// APB completer-side bus bundle.
// Master drives select/enable/write/addr/wdata; slave returns ready/rdata/slverr.
interface apb_regfile_slave_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) ();

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic [DATA_W-1:0] prdata;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, prdata, pslverr
  );

endinterface

// File: rtl/apb_regfile_slave_regbank.sv
// DEPTH x DATA_W storage, one write port, combinational read port.
// Ports: clk, rst_n (async clear), we/waddr/wdata, raddr -> rdata.
module apb_regbank #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 8,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/apb_regfile_slave.sv
// APB completer with a byte register bank, programmable wait states, PSLVERR.
// Ports: pclk, rst_n (async low), bus (slave modport of apb_regfile_slave_if).
module apb_regfile_slave
  import apb_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 8,
  parameter int DEPTH      = 64,
  parameter int RESET_WAIT = 1
) (
  input logic                 pclk,
  input logic                 rst_n,
  apb_regfile_slave_if.slave  bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] CFG_A = ADDR_W'(CFG_ADDR);

  apb_slv_state_t state_q, state_d;

  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [WAIT_W-1:0] wait_q;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;

  logic              pready_q;
  logic [DATA_W-1:0] prdata_q;
  logic              pslverr_q;

  logic              setup;
  logic              commit;
  logic [ADDR_W-1:0] a_sel;
  logic              w_sel;
  logic              cfg_sel;
  logic              err_sel;
  logic              err_in;
  logic [DATA_W-1:0] bank_rd;
  logic [DATA_W-1:0] rd_val;
  logic              bank_we;
  logic              cfg_we;

  assign setup  = bus.psel && !bus.penable;
  assign err_in = !(32'(bus.paddr) < 32'(DEPTH)) && (bus.paddr != CFG_A);

  // In IDLE the transfer is not captured yet, so a zero-wait READY
  // entry must decode straight off the bus.
  always_comb begin
    a_sel   = addr_q;
    w_sel   = write_q;
    err_sel = err_q;
    if (state_q == IDLE) begin
      a_sel   = bus.paddr;
      w_sel   = bus.pwrite;
      err_sel = err_in;
    end
  end

  assign cfg_sel = (a_sel == CFG_A);
  assign rd_val  = cfg_sel ? DATA_W'(wait_q) : bank_rd;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (setup) begin
          if (wait_q == '0) begin
            state_d = READY;
          end else begin
            state_d = WAIT;
            cnt_d   = wait_q;
          end
        end
      end
      WAIT: begin
        if (!bus.psel) begin
          state_d = IDLE;
        end else if (bus.penable) begin
          if (cnt_q == WAIT_W'(1)) begin
            state_d = READY;
          end else begin
            cnt_d = cnt_q - WAIT_W'(1);
          end
        end
      end
      READY: begin
        state_d = IDLE;
        commit  = bus.psel && bus.penable && !err_q;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bank_we = commit && write_q && (addr_q != CFG_A);
  assign cfg_we  = commit && write_q && (addr_q == CFG_A);

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && setup) begin
        addr_q  <= bus.paddr;
        write_q <= bus.pwrite;
        wdata_q <= bus.pwdata;
        err_q   <= err_in;
      end
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= WAIT_W'(RESET_WAIT);
    end else if (cfg_we) begin
      wait_q <= wdata_q[WAIT_W-1:0];
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      pready_q  <= (state_d == READY);
      pslverr_q <= (state_d == READY) && err_sel;
      if (state_d == READY && !w_sel && !err_sel) begin
        prdata_q <= rd_val;
      end else begin
        prdata_q <= '0;
      end
    end
  end

  apb_regbank #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_bank (
    .clk   (pclk),
    .rst_n (rst_n),
    .we    (bank_we),
    .waddr (addr_q[IDX_W-1:0]),
    .wdata (wdata_q),
    .raddr (a_sel[IDX_W-1:0]),
    .rdata (bank_rd)
  );

  assign bus.pready  = pready_q;
  assign bus.prdata  = prdata_q;
  assign bus.pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed bench for apb_regfile_slave.
// Drives APB transfers, checks latency, data, error and abort/reset behaviour.
module tb_apb_regfile_slave;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  apb_regfile_slave_if #(.DATA_W(8), .ADDR_W(8)) bus ();

  apb_regfile_slave #(
    .DATA_W     (8),
    .ADDR_W     (8),
    .DEPTH      (64),
    .RESET_WAIT (1)
  ) dut (
    .pclk  (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts just after a rising edge; returns the access cycle index
  // (1 = T1) in which pready was seen, or 99 on timeout.
  task automatic xfer(input logic w, input logic [7:0] a,
                      input logic [7:0] d, output logic [7:0] rd,
                      output logic er, output int acc,
                      output logic zero_ok);
    bit done;
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = w;
    bus.paddr   = a;
    bus.pwdata  = d;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    acc = 0; rd = '0; er = 1'b0; done = 0; zero_ok = 1'b1;
    while (!done && acc < 20) begin
      @(negedge clk);
      acc++;
      if (bus.pready) begin
        rd = bus.prdata; er = bus.pslverr; done = 1;
      end else if (bus.prdata !== 8'h00) begin
        zero_ok = 1'b0;
      end
    end
    if (!done) acc = 99;
    @(posedge clk); #1;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
  endtask

  logic [7:0] rd;
  logic       er;
  logic       zok;
  int         acc;
  int         hi;

  initial begin
    rst_n = 1'b0;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0; bus.pwdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pready", 32'(bus.pready), 32'h0);
    chk("rst_prdata", 32'(bus.prdata), 32'h0);
    chk("rst_pslverr", 32'(bus.pslverr), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    xfer(0, 8'hFF, 8'h00, rd, er, acc, zok);
    chk("cfg_rst_lat", 32'(acc), 32'd2);
    chk("cfg_rst_val", 32'(rd), 32'h01);
    chk("cfg_rst_err", 32'(er), 32'h0);
    xfer(0, 8'h05, 8'h00, rd, er, acc, zok);
    chk("r5_rst_val", 32'(rd), 32'h00);

    xfer(1, 8'hFF, 8'h00, rd, er, acc, zok);
    chk("cfg0_wr_lat", 32'(acc), 32'd2);
    xfer(1, 8'h03, 8'hA5, rd, er, acc, zok);
    chk("w3_lat0", 32'(acc), 32'd1);
    chk("w3_prdata", 32'(rd), 32'h00);
    xfer(0, 8'h03, 8'h00, rd, er, acc, zok);
    chk("r3_lat0", 32'(acc), 32'd1);
    chk("r3_val", 32'(rd), 32'hA5);

    xfer(1, 8'hFF, 8'h07, rd, er, acc, zok);
    chk("cfg7_wr_lat", 32'(acc), 32'd1);
    xfer(0, 8'h03, 8'h00, rd, er, acc, zok);
    chk("r3_lat7", 32'(acc), 32'd8);
    chk("r3_val7", 32'(rd), 32'hA5);
    chk("r3_zero_wait", 32'(zok), 32'h1);
    xfer(0, 8'hFF, 8'h00, rd, er, acc, zok);
    chk("cfg7_rd", 32'(rd), 32'h07);

    xfer(1, 8'h40, 8'h5A, rd, er, acc, zok);
    chk("w40_err", 32'(er), 32'h1);
    chk("w40_lat", 32'(acc), 32'd8);
    xfer(0, 8'h40, 8'h00, rd, er, acc, zok);
    chk("r40_err", 32'(er), 32'h1);
    chk("r40_val", 32'(rd), 32'h00);
    xfer(0, 8'h00, 8'h00, rd, er, acc, zok);
    chk("r0_unchanged", 32'(rd), 32'h00);
    chk("r0_err", 32'(er), 32'h0);

    xfer(1, 8'hFF, 8'h03, rd, er, acc, zok);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 8'h03; bus.pwdata = 8'h11;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    hi = 0;
    @(negedge clk);
    if (bus.pready) hi++;
    @(posedge clk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.pready) hi++;
    end
    chk("abort_no_ready", 32'(hi), 32'd0);
    @(posedge clk); #1;
    xfer(0, 8'h03, 8'h00, rd, er, acc, zok);
    chk("abort_no_write", 32'(rd), 32'hA5);
    chk("abort_next_lat", 32'(acc), 32'd4);

    xfer(1, 8'h07, 8'h3C, rd, er, acc, zok);
    xfer(0, 8'h07, 8'h00, rd, er, acc, zok);
    chk("r7_val", 32'(rd), 32'h3C);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 8'h07; bus.pwdata = 8'h22;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pready", 32'(bus.pready), 32'h0);
    chk("mid_rst_prdata", 32'(bus.prdata), 32'h0);
    chk("mid_rst_pslverr", 32'(bus.pslverr), 32'h0);
    bus.psel = 1'b0; bus.penable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(0, 8'hFF, 8'h00, rd, er, acc, zok);
    chk("post_rst_cfg", 32'(rd), 32'h01);
    chk("post_rst_lat", 32'(acc), 32'd2);
    xfer(0, 8'h07, 8'h00, rd, er, acc, zok);
    chk("post_rst_r7", 32'(rd), 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
